uart_tx_arbiter: RTL and testbench

- Shares the single UART TX FIFO write port among three report sources: req0 = stopwatch/watch, req1 = SR04, req2 = DHT11.
- Each source streams a byte packet (valid/ready/last). The arbiter grants one source at a time using round-robin order.
- A grant is held until the packet's last byte enters the FIFO, or until the source stalls past a timeout.
- A per-source enable mask, driven from the mode control unit, gates which sources may win arbitration.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the per-source packet streams, TX FIFO write port and arbiter status.
interface uart_tx_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [2:0]          mask;
  logic [2:0]          req_valid;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_last;
  logic [2:0]          req_ready;
  logic                fifo_full;
  logic                fifo_wr;
  logic [DATA_W-1:0]   fifo_wdata;
  logic [2:0]          grant;
  logic                busy;
  logic                timeout_err;

  // Sources, mode control and FIFO side
  modport master (
    output mask, req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr, fifo_wdata, grant, busy, timeout_err
  );

  // Arbiter side
  modport slave (
    input  mask, req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr, fifo_wdata, grant, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among three packet
// sources (0 = stopwatch/watch, 1 = SR04, 2 = DHT11). A grant is held until the
// last byte is written or the owner starves past TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t             r_state;
  logic [2:0]         r_grant;
  logic [1:0]         r_last_winner;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout_err;

  logic [2:0]         w_eligible;
  logic [2:0]         w_pick;
  logic [1:0]         w_gidx;
  logic               w_own_valid;
  logic               w_own_last;
  logic [DATA_W-1:0]  w_own_data;
  logic               w_busy;
  logic               w_wr;
  logic               w_starved;

  assign w_eligible  = bus.req_valid & bus.mask;
  assign w_busy      = (r_state == XFER);
  assign w_own_valid = |(bus.req_valid & r_grant);
  assign w_own_last  = |(bus.req_last & r_grant);
  assign w_wr        = w_busy & w_own_valid & ~bus.fifo_full;
  assign w_starved   = w_busy & ~w_own_valid & ~bus.fifo_full;
  assign w_gidx      = r_grant[2] ? 2'd2 : (r_grant[1] ? 2'd1 : 2'd0);

  // Select the owner's byte from the packed source bus
  always_comb begin
    w_own_data = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_grant[i]) w_own_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: search starts just after the previous winner
  always_comb begin
    w_pick = '0;
    case (r_last_winner)
      2'd0: begin
        if      (w_eligible[1]) w_pick = 3'b010;
        else if (w_eligible[2]) w_pick = 3'b100;
        else if (w_eligible[0]) w_pick = 3'b001;
      end
      2'd1: begin
        if      (w_eligible[2]) w_pick = 3'b100;
        else if (w_eligible[0]) w_pick = 3'b001;
        else if (w_eligible[1]) w_pick = 3'b010;
      end
      default: begin
        if      (w_eligible[0]) w_pick = 3'b001;
        else if (w_eligible[1]) w_pick = 3'b010;
        else if (w_eligible[2]) w_pick = 3'b100;
      end
    endcase
  end

  // Arbitration FSM with grant, starvation counter and timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_last_winner <= 2'd2;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_eligible) begin
            r_grant <= w_pick;
            r_cnt   <= '0;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_wr) begin
            r_cnt <= '0;
            if (w_own_last) begin
              r_state       <= IDLE;
              r_grant       <= '0;
              r_last_winner <= w_gidx;
            end
          end else if (w_starved) begin
            if (r_cnt == CNT_W'(TIMEOUT)) begin
              r_state       <= IDLE;
              r_grant       <= '0;
              r_last_winner <= w_gidx;
              r_cnt         <= '0;
              r_timeout_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (w_busy && !bus.fifo_full) ? r_grant : '0;
  assign bus.fifo_wr     = w_wr;
  assign bus.fifo_wdata  = w_wr ? w_own_data : '0;
  assign bus.grant       = r_grant;
  assign bus.busy        = w_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: source byte queues drive the packet
// streams, expected FIFO writes are queued at stimulus time and popped on fifo_wr.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_W(8)) bus();

  uart_tx_arbiter #(.DATA_W(8), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         src;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] sq0[$];
  logic [8:0] sq1[$];
  logic [8:0] sq2[$];
  int         wr_cyc_q[$];

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         wr_count = 0;
  int         to_count = 0;
  int         to_cyc = -1;
  logic [2:0] grant_at_to = '0;
  bit         check_ready_lo = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] d, input logic last, input bit expect_wr);
    case (s)
      0:       sq0.push_back({last, d});
      1:       sq1.push_back({last, d});
      default: sq2.push_back({last, d});
    endcase
    if (expect_wr) exp_q.push_back('{src: s, data: d});
  endtask

  // {valid, last, data} of a source's head byte
  function automatic logic [9:0] head(input int s);
    case (s)
      0:       return (sq0.size() != 0) ? {1'b1, sq0[0]} : 10'd0;
      1:       return (sq1.size() != 0) ? {1'b1, sq1[0]} : 10'd0;
      default: return (sq2.size() != 0) ? {1'b1, sq2[0]} : 10'd0;
    endcase
  endfunction

  function automatic int gap(input int i);
    if (wr_cyc_q.size() > i + 1) return wr_cyc_q[i+1] - wr_cyc_q[i];
    return -1;
  endfunction

  function automatic bit all_idle();
    return exp_q.size() == 0 && sq0.size() == 0 && sq1.size() == 0 &&
           sq2.size() == 0 && !bus.busy;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_wr(input int target, input int budget);
    int n = 0;
    while (wr_count < target && n < budget) begin
      step();
      n++;
    end
    chk("wait_wr", wr_count >= target, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    chk("drain", all_idle(), 1);
  endtask

  // Source drivers and FIFO-side monitor
  initial begin
    logic [2:0] hs;
    logic [9:0] h;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        h = head(i);
        bus.req_valid[i]       = h[9];
        bus.req_last[i]        = h[8];
        bus.req_data[i*8 +: 8] = h[7:0];
      end
      #1;
      hs = bus.req_valid & bus.req_ready;
      chk("wr_when_full", bus.fifo_wr & bus.fifo_full, 0);
      if (bus.fifo_wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wdata", bus.fifo_wdata, e.data);
          chk("wr_src", bus.grant, 32'(3'b001 << e.src));
        end
        wr_count++;
        wr_cyc_q.push_back(cyc);
      end else begin
        chk("wdata_idle", bus.fifo_wdata, 0);
      end
      if (check_ready_lo) chk("mask_ready", bus.req_ready[1:0], 0);
      if (bus.timeout_err) begin
        to_count++;
        to_cyc      = cyc;
        grant_at_to = bus.grant;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (hs[0]) sq0.delete(0);
      if (hs[1]) sq1.delete(0);
      if (hs[2]) sq2.delete(0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int tb_to;
    int n;
    rst           = 1'b1;
    bus.mask      = 3'b111;
    bus.fifo_full = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr", bus.fifo_wr, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_wdata", bus.fifo_wdata, 0);
    chk("rst_to", bus.timeout_err, 0);
    rst = 1'b0;
    step();

    // Round-robin from reset, twice
    for (int r = 0; r < 2; r++) begin
      wr_cyc_q.delete();
      push_byte(0, 8'hA0, 1'b1, 1'b1);
      push_byte(1, 8'hB1, 1'b1, 1'b1);
      push_byte(2, 8'hC2, 1'b1, 1'b1);
      drain(50);
      chk("rr_nwr", wr_cyc_q.size(), 3);
      chk("rr_gap0", gap(0), 2);
      chk("rr_gap1", gap(1), 2);
    end

    // Single src1 packet
    wr_cyc_q.delete();
    push_byte(1, 8'h41, 1'b0, 1'b1);
    push_byte(1, 8'h42, 1'b0, 1'b1);
    push_byte(1, 8'h0D, 1'b1, 1'b1);
    step();
    chk("sp_grant", bus.grant, 3'b010);
    chk("sp_busy", bus.busy, 1);
    drain(50);
    chk("sp_nwr", wr_cyc_q.size(), 3);
    chk("sp_gap0", gap(0), 1);
    chk("sp_gap1", gap(1), 1);
    chk("sp_grant_end", bus.grant, 0);

    // Backpressure: 300-cycle FIFO full stall mid-packet
    base = wr_count;
    tb_to = to_count;
    push_byte(0, 8'h10, 1'b0, 1'b1);
    push_byte(0, 8'h11, 1'b0, 1'b1);
    push_byte(0, 8'h12, 1'b0, 1'b1);
    push_byte(0, 8'h13, 1'b1, 1'b1);
    wait_wr(base + 2, 20);
    bus.fifo_full = 1'b1;
    repeat (300) step();
    chk("bp_no_wr", wr_count, base + 2);
    chk("bp_no_to", to_count, tb_to);
    chk("bp_busy", bus.busy, 1);
    chk("bp_ready", bus.req_ready, 0);
    bus.fifo_full = 1'b0;
    drain(50);
    chk("bp_total", wr_count, base + 4);

    // Mask: only src2 eligible, mask cleared mid-packet
    base = wr_count;
    bus.mask = 3'b100;
    push_byte(0, 8'h30, 1'b1, 1'b0);
    push_byte(1, 8'h31, 1'b1, 1'b0);
    push_byte(2, 8'h20, 1'b0, 1'b1);
    push_byte(2, 8'h21, 1'b0, 1'b1);
    push_byte(2, 8'h22, 1'b1, 1'b1);
    check_ready_lo = 1'b1;
    wait_wr(base + 1, 20);
    bus.mask = 3'b000;
    repeat (10) step();
    check_ready_lo = 1'b0;
    chk("mask_done", wr_count, base + 3);
    chk("mask_grant", bus.grant, 0);
    bus.mask = 3'b111;
    exp_q.push_back('{src: 0, data: 8'h30});
    exp_q.push_back('{src: 1, data: 8'h31});
    drain(50);

    // Timeout: src1 stalls after one byte
    wr_cyc_q.delete();
    tb_to = to_count;
    push_byte(1, 8'h50, 1'b0, 1'b1);
    n = 0;
    while (bus.grant != 3'b010 && n < 10) begin
      step();
      n++;
    end
    chk("to_granted", bus.grant, 3'b010);
    push_byte(2, 8'h60, 1'b1, 1'b1);
    push_byte(0, 8'h70, 1'b1, 1'b1);
    n = 0;
    while (to_count == tb_to && n < 30) begin
      step();
      n++;
    end
    chk("to_seen", to_count, tb_to + 1);
    chk("to_cycle", to_cyc - ((wr_cyc_q.size() != 0) ? wr_cyc_q[0] : 0), 6);
    chk("to_grant", grant_at_to, 0);
    drain(50);
    chk("to_once", to_count, tb_to + 1);

    // Reset in the middle of a src0 packet
    base = wr_count;
    push_byte(0, 8'h80, 1'b0, 1'b1);
    push_byte(0, 8'h81, 1'b0, 1'b1);
    push_byte(0, 8'h82, 1'b0, 1'b0);
    push_byte(0, 8'h83, 1'b1, 1'b0);
    wait_wr(base + 2, 20);
    rst = 1'b1;
    #1;
    chk("mr_grant", bus.grant, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_wr", bus.fifo_wr, 0);
    chk("mr_ready", bus.req_ready, 0);
    exp_q.push_back('{src: 0, data: 8'h82});
    exp_q.push_back('{src: 0, data: 8'h83});
    push_byte(1, 8'h90, 1'b1, 1'b1);
    step();
    step();
    rst = 1'b0;
    step();
    chk("mr_src0_first", bus.grant, 3'b001);
    drain(50);

    chk("to_total", to_count, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
